// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer for the 16-bit core: fetch, decode, execute/multiply/memory/jump, trap.
// Optional single-step mode is enabled by defining SEQ_STEP_EN (adds the step_req input).
module seq_ctrl #(
    parameter int MUL_MAX_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SEQ_STEP_EN
    input  logic        step_req,
`endif
    input  logic [15:0] instr_rdata,
    input  logic        mem_ack,
    input  logic        alu_cout,
    input  logic        mul_done,
    output logic [15:0] ir_q,
    output logic        carry_q,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        rf_we,
    output logic        mul_start,
    output logic        busy,
    output logic        trap
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MUL, MEM, JUMP, TRAP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mul_first_q;
    logic               fetch_en;

    logic [4:0] op;
    logic       is_alu, is_mul, is_ld, is_st, is_jmp, is_nop, carry_wr;

    assign op = ir_q[15:11];

    always_comb begin
        is_alu   = 1'b0;
        is_mul   = 1'b0;
        is_ld    = 1'b0;
        is_st    = 1'b0;
        is_jmp   = 1'b0;
        is_nop   = 1'b0;
        carry_wr = 1'b0;
        case (op)
            5'b00000: is_nop = 1'b1;
            5'b01001: begin is_mul = 1'b1; carry_wr = 1'b1; end
            5'b01110: is_ld  = 1'b1;
            5'b01111: is_st  = 1'b1;
            5'b11100: is_jmp = 1'b1;
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b00111, 5'b01000, 5'b01010, 5'b01011: begin
                is_alu   = 1'b1;
                carry_wr = 1'b1;
            end
            // bbo and stk execute but leave the carry flag alone
            5'b01100, 5'b01101: is_alu = 1'b1;
            default: ;
        endcase
    end

`ifdef SEQ_STEP_EN
    logic go_q;
    assign fetch_en = go_q;
`else
    assign fetch_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            mul_first_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (fetch_en && mem_ack) begin
                        ir_q    <= instr_rdata;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_alu)              state_q <= EXEC;
                    else if (is_mul) begin
                        state_q     <= MUL;
                        mul_first_q <= 1'b1;
                    end
                    else if (is_ld || is_st) state_q <= MEM;
                    else if (is_jmp)         state_q <= JUMP;
                    else if (is_nop)         state_q <= FETCH;
                    else                     state_q <= TRAP;
                end
                EXEC: begin
                    if (carry_wr) carry_q <= alu_cout;
                    state_q <= FETCH;
                end
                MUL: begin
                    mul_first_q <= 1'b0;
                    if (mul_done) begin
                        carry_q <= alu_cout;
                        state_q <= FETCH;
                    end else if (mul_first_q) begin
                        cnt_q <= '0;
                    // the increment that would land on MUL_MAX_CYC-1 is the timeout
                    end else if (cnt_q == CNT_W'(MUL_MAX_CYC - 2)) begin
                        state_q <= TRAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MEM: begin
                    if (mem_ack) state_q <= FETCH;
                end
                JUMP:    state_q <= FETCH;
                TRAP:    state_q <= TRAP;
                default: state_q <= TRAP;
            endcase
        end
    end

`ifdef SEQ_STEP_EN
    // step permission is consumed by the fetch it releases, so each pulse yields one instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q <= 1'b0;
        end else if (state_q == FETCH) begin
            if (go_q && mem_ack) go_q <= 1'b0;
            else if (step_req)   go_q <= 1'b1;
        end
    end
`endif

    // outputs are gated by rst_n so an in-flight request drops the moment reset asserts
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        rf_we     = 1'b0;
        mul_start = 1'b0;
        busy      = 1'b0;
        trap      = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_req = fetch_en;
                    pc_inc  = fetch_en & mem_ack;
                    busy    = fetch_en;
                end
                DECODE: busy = 1'b1;
                EXEC: begin
                    rf_we = 1'b1;
                    busy  = 1'b1;
                end
                MUL: begin
                    mul_start = mul_first_q;
                    rf_we     = mul_done;
                    busy      = 1'b1;
                end
                MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = is_st;
                    rf_we    = mem_ack & is_ld;
                    busy     = 1'b1;
                end
                JUMP: begin
                    pc_load = 1'b1;
                    busy    = 1'b1;
                end
                TRAP:    trap = 1'b1;
                default: trap = 1'b1;
            endcase
        end
    end

endmodule
